mos_alu: RTL and testbench
==========================

Name: mos_alu

Overview:
- 8-bit registered ALU for the 6502-style datapath.
- Takes the accumulator, a second operand and the current processor status byte.
- Produces a result byte and an updated status byte one clock after the inputs are applied.
- Binary arithmetic only; the decimal flag is carried through unchanged and never alters arithmetic.

Parameters:
- none (width fixed at 8, opcode width fixed at 4)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset; one clock; reset is synchronous and active-low
- op  input  4  operation select (encoding below)
- accumulator  input  8  A operand
- operand_2  input  8  B operand; memory/register operand for unary ops
- status  input  8  current flags, 6502 layout: [7]N [6]V [5]unused [4]B [3]D [2]I [1]Z [0]C
- result  output  8  registered result
- status_out  output  8  registered updated flags

Behaviour:
- All outputs are registered on the rising clk edge; latency is 1 cycle; no handshake.
  - The inputs present at edge k determine the outputs after edge k.
  - Inputs are sampled every cycle.
- Reset: rst=0 at a rising edge forces result=8'h00 and status_out=8'h00.
  - Reset overrides any op, including mid-stream; no other state exists.
- Flags not listed for an op copy the corresponding status input bit to status_out.
  - Bits 5, 4, 3 and 2 always pass through unchanged.
- Z is 1 when the stated value is 8'h00. N is bit 7 of the stated value.
- Opcode encoding (A=accumulator, M=operand_2, Cin=status[0]):
  - 0 ADC: R = A+M+Cin. C = carry out of bit 7. V = (A[7]==M[7]) && (R[7]!=A[7]). N, Z from R.
  - 1 SBC: R = A+~M+Cin. C = carry out (1 = no borrow). V = (A[7]!=M[7]) && (R[7]!=A[7]). N, Z from R.
  - 2 AND: R = A&M. N, Z from R.
  - 3 ORA: R = A|M. N, Z from R.
  - 4 EOR: R = A^M. N, Z from R.
  - 5 ASL: R = {M[6:0],0}. C = M[7]. N, Z from R.
  - 6 LSR: R = {0,M[7:1]}. C = M[0]. N = 0. Z from R.
  - 7 ROL: R = {M[6:0],Cin}. C = M[7]. N, Z from R.
  - 8 ROR: R = {Cin,M[7:1]}. C = M[0]. N, Z from R.
  - 9 INC: R = M+1, wraps FF->00. N, Z from R. C, V unchanged.
  - 10 DEC: R = M-1, wraps 00->FF. N, Z from R. C, V unchanged.
  - 11 CMP: D = A-M (8-bit). R = A. C = (A>=M) unsigned. Z = (A==M). N = D[7]. V unchanged.
  - 12 BIT: R = A. Z from A&M. N = M[7]. V = M[6]. C unchanged.
  - 13 PASSM: R = M. N, Z from R (transfer/load path).
  - 14 PASSA: R = A. N, Z from R.
  - 15 NOP: R = A. status_out = status exactly.
- All arithmetic is modulo 256; the carry is taken from a 9-bit sum.
- For ASL/LSR/ROL/ROR, accumulator-mode shifts are implemented upstream by routing A onto operand_2.

Test Plan:
- Reset: hold rst=0 for 2 edges with op=0, A=8'h7F, M=8'h01, status=8'hFF -> result=8'h00, status_out=8'h00. Release rst; the next edge gives result=8'h81.
- ADC overflow: op=0, A=8'h50, M=8'h50, status=8'h00 -> result=8'hA0, status_out=8'hC0 (N=1, V=1, Z=0, C=0). A=8'hFF, M=8'h01, Cin=1 -> result=8'h01, C=1, Z=0.
- SBC overflow: op=1, A=8'h50, M=8'hB0, status=8'h01 -> result=8'hA0, N=1, V=1, C=0. A=8'h05, M=8'h05, Cin=1 -> result=8'h00, Z=1, C=1.
- Logic ops: op=2, A=8'hF0, M=8'h0F -> result=8'h00, Z=1. op=3 same operands -> 8'hFF, N=1. op=4, A=8'hAA, M=8'hFF -> 8'h55, N=0, Z=0. Status bits 5..2 echo input (status=8'h3C -> those bits stay 1).
- Shifts/rotates: op=7, M=8'h80, Cin=0 -> result=8'h00, C=1, Z=1. op=8, M=8'h01, Cin=1 -> 8'h80, C=1, N=1. op=6, M=8'h01 -> 8'h00, C=1, Z=1.
- CMP/BIT/INC/DEC and back-to-back ops:
  - op=11, A=8'h10, M=8'h20 -> result=8'h10, C=0, N=1, Z=0.
  - op=12, A=8'h0F, M=8'hC0 -> Z=1, N=1, V=1.
  - op=9, M=8'hFF -> 8'h00, Z=1. op=10, M=8'h00 -> 8'hFF, N=1.
  - Change op every cycle; each output must reflect the prior cycle's inputs.

Source files
------------

// File: rtl/mos_alu.sv
// -----------------------------------------------------------------------------
// mos_alu
//   8-bit registered ALU for a 6502-style datapath. Binary arithmetic only;
//   the decimal flag is carried through unchanged. The result byte and the
//   updated status byte appear one clock after the inputs are applied.
//
// Ports
//   clk          in   1  system clock, rising-edge active
//   rst          in   1  synchronous active-low reset (clears both outputs)
//   op           in   4  operation select (see localparams below)
//   accumulator  in   8  A operand
//   operand_2    in   8  M operand; source for the unary ops
//   status       in   8  current flags {N,V,-,B,D,I,Z,C}
//   result       out  8  registered result byte
//   status_out   out  8  registered updated flags
// -----------------------------------------------------------------------------
module mos_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op,
    input  logic [7:0] accumulator,
    input  logic [7:0] operand_2,
    input  logic [7:0] status,
    output logic [7:0] result,
    output logic [7:0] status_out
);

    localparam logic [3:0] OP_ADC   = 4'd0;
    localparam logic [3:0] OP_SBC   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_ORA   = 4'd3;
    localparam logic [3:0] OP_EOR   = 4'd4;
    localparam logic [3:0] OP_ASL   = 4'd5;
    localparam logic [3:0] OP_LSR   = 4'd6;
    localparam logic [3:0] OP_ROL   = 4'd7;
    localparam logic [3:0] OP_ROR   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_CMP   = 4'd11;
    localparam logic [3:0] OP_BIT   = 4'd12;
    localparam logic [3:0] OP_PASSM = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_NOP   = 4'd15;

    logic [7:0] w_a;
    logic [7:0] w_m;
    logic       w_cin;
    logic [8:0] w_adc_sum;
    logic [8:0] w_sbc_sum;
    logic [8:0] w_cmp_sum;
    logic [7:0] w_and;
    logic [7:0] w_result;
    logic       w_n;
    logic       w_v;
    logic       w_z;
    logic       w_c;
    logic [7:0] w_status;
    logic [7:0] r_result;
    logic [7:0] r_status;

    assign w_a   = accumulator;
    assign w_m   = operand_2;
    assign w_cin = status[0];
    assign w_and = w_a & w_m;

    // Nine-bit sums: bit 8 is the carry out. SBC and CMP add the one's
    // complement of M, so carry=1 means "no borrow" (A >= M for CMP).
    assign w_adc_sum = {1'b0, w_a} + {1'b0, w_m} + {8'h00, w_cin};
    assign w_sbc_sum = {1'b0, w_a} + {1'b0, ~w_m} + {8'h00, w_cin};
    assign w_cmp_sum = {1'b0, w_a} + {1'b0, ~w_m} + 9'd1;

    // Next result and flags; flags an op does not touch keep their input value.
    always_comb begin
        w_result = w_a;
        w_n      = status[7];
        w_v      = status[6];
        w_z      = status[1];
        w_c      = status[0];
        case (op)
            OP_ADC: begin
                w_result = w_adc_sum[7:0];
                w_c      = w_adc_sum[8];
                w_v      = (w_a[7] == w_m[7]) && (w_adc_sum[7] != w_a[7]);
                w_n      = w_adc_sum[7];
                w_z      = (w_adc_sum[7:0] == 8'h00);
            end
            OP_SBC: begin
                w_result = w_sbc_sum[7:0];
                w_c      = w_sbc_sum[8];
                w_v      = (w_a[7] != w_m[7]) && (w_sbc_sum[7] != w_a[7]);
                w_n      = w_sbc_sum[7];
                w_z      = (w_sbc_sum[7:0] == 8'h00);
            end
            OP_AND: begin
                w_result = w_and;
                w_n      = w_and[7];
                w_z      = (w_and == 8'h00);
            end
            OP_ORA: begin
                w_result = w_a | w_m;
                w_n      = w_a[7] | w_m[7];
                w_z      = ((w_a | w_m) == 8'h00);
            end
            OP_EOR: begin
                w_result = w_a ^ w_m;
                w_n      = w_a[7] ^ w_m[7];
                w_z      = ((w_a ^ w_m) == 8'h00);
            end
            OP_ASL: begin
                w_result = {w_m[6:0], 1'b0};
                w_c      = w_m[7];
                w_n      = w_m[6];
                w_z      = (w_m[6:0] == 7'h00);
            end
            OP_LSR: begin
                w_result = {1'b0, w_m[7:1]};
                w_c      = w_m[0];
                w_n      = 1'b0;
                w_z      = (w_m[7:1] == 7'h00);
            end
            OP_ROL: begin
                w_result = {w_m[6:0], w_cin};
                w_c      = w_m[7];
                w_n      = w_m[6];
                w_z      = ({w_m[6:0], w_cin} == 8'h00);
            end
            OP_ROR: begin
                w_result = {w_cin, w_m[7:1]};
                w_c      = w_m[0];
                w_n      = w_cin;
                w_z      = ({w_cin, w_m[7:1]} == 8'h00);
            end
            OP_INC: begin
                w_result = w_m + 8'h01;
                w_n      = w_result[7];
                w_z      = (w_result == 8'h00);
            end
            OP_DEC: begin
                w_result = w_m - 8'h01;
                w_n      = w_result[7];
                w_z      = (w_result == 8'h00);
            end
            OP_CMP: begin
                w_result = w_a;
                w_c      = w_cmp_sum[8];
                w_n      = w_cmp_sum[7];
                w_z      = (w_a == w_m);
            end
            OP_BIT: begin
                w_result = w_a;
                w_z      = (w_and == 8'h00);
                w_n      = w_m[7];
                w_v      = w_m[6];
            end
            OP_PASSM: begin
                w_result = w_m;
                w_n      = w_m[7];
                w_z      = (w_m == 8'h00);
            end
            OP_PASSA: begin
                w_result = w_a;
                w_n      = w_a[7];
                w_z      = (w_a == 8'h00);
            end
            OP_NOP: begin
                w_result = w_a;
            end
            default: begin
                w_result = w_a;
            end
        endcase
    end

    // Bits 5..2 (unused, B, D, I) always pass straight through.
    assign w_status = {w_n, w_v, status[5:2], w_z, w_c};

    // Output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_result <= 8'h00;
            r_status <= 8'h00;
        end else begin
            r_result <= w_result;
            r_status <= w_status;
        end
    end

    assign result     = r_result;
    assign status_out = r_status;

endmodule

// File: tb/tb_mos_alu.sv
// -----------------------------------------------------------------------------
// tb_mos_alu
//   Directed self-checking bench for mos_alu. Each test task applies vectors
//   with hand-computed expected result/status and compares after the edge.
// -----------------------------------------------------------------------------
module tb_mos_alu;

    logic       clk;
    logic       rst;
    logic [3:0] op;
    logic [7:0] accumulator;
    logic [7:0] operand_2;
    logic [7:0] status;
    logic [7:0] result;
    logic [7:0] status_out;

    int n_cmp;
    int n_err;

    mos_alu dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .accumulator (accumulator),
        .operand_2   (operand_2),
        .status      (status),
        .result      (result),
        .status_out  (status_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs, then let one rising edge capture them.
    task automatic step(input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] m, input logic [7:0] s);
        op          = o;
        accumulator = a;
        operand_2   = m;
        status      = s;
        @(posedge clk);
        #1;
    endtask

    // Runs a table of vectors; each row = {op, A, M, status, exp_result, exp_status}.
    task automatic run_table(input string name, input logic [43:0] vec [],
                             input int n);
        for (int i = 0; i < n; i++) begin
            step(vec[i][43:40], vec[i][39:32], vec[i][31:24], vec[i][23:16]);
            n_cmp++;
            if (result !== vec[i][15:8]) begin
                n_err++;
                $display("FAIL %s[%0d] result: got %h expected %h", name, i, result, vec[i][15:8]);
            end
            n_cmp++;
            if (status_out !== vec[i][7:0]) begin
                n_err++;
                $display("FAIL %s[%0d] status_out: got %h expected %h", name, i, status_out, vec[i][7:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(4'd0, 8'h7F, 8'h01, 8'hFF);
            n_cmp++;
            if (result !== 8'h00 || status_out !== 8'h00) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h/%h expected 00/00", i, result, status_out);
            end
        end
        rst = 1'b1;
        step(4'd0, 8'h7F, 8'h01, 8'hFF);
        n_cmp++;
        if (result !== 8'h81 || status_out !== 8'hFC) begin
            n_err++;
            $display("FAIL reset_release: got %h/%h expected 81/FC", result, status_out);
        end
    endtask

    task automatic test_arith();
        logic [43:0] v [];
        v = new[4];
        v[0] = {4'd0, 8'h50, 8'h50, 8'h00, 8'hA0, 8'hC0};
        v[1] = {4'd0, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01};
        v[2] = {4'd1, 8'h50, 8'hB0, 8'h01, 8'hA0, 8'hC0};
        v[3] = {4'd1, 8'h05, 8'h05, 8'h01, 8'h00, 8'h03};
        run_table("arith", v, 4);
    endtask

    task automatic test_logic();
        logic [43:0] v [];
        v = new[4];
        v[0] = {4'd2, 8'hF0, 8'h0F, 8'h00, 8'h00, 8'h02};
        v[1] = {4'd3, 8'hF0, 8'h0F, 8'h3C, 8'hFF, 8'hBC};
        v[2] = {4'd4, 8'hAA, 8'hFF, 8'h3C, 8'h55, 8'h3C};
        v[3] = {4'd2, 8'hF0, 8'h0F, 8'h3C, 8'h00, 8'h3E};
        run_table("logic", v, 4);
    endtask

    task automatic test_shift();
        logic [43:0] v [];
        v = new[4];
        v[0] = {4'd7, 8'h00, 8'h80, 8'h00, 8'h00, 8'h03};
        v[1] = {4'd8, 8'h00, 8'h01, 8'h01, 8'h80, 8'h81};
        v[2] = {4'd6, 8'h00, 8'h01, 8'h80, 8'h00, 8'h03};
        v[3] = {4'd5, 8'h00, 8'hC1, 8'h00, 8'h82, 8'h81};
        run_table("shift", v, 4);
    endtask

    task automatic test_misc();
        logic [43:0] v [];
        v = new[7];
        v[0] = {4'd11, 8'h10, 8'h20, 8'h40, 8'h10, 8'hC0};
        v[1] = {4'd12, 8'h0F, 8'hC0, 8'h01, 8'h0F, 8'hC3};
        v[2] = {4'd9,  8'h00, 8'hFF, 8'h41, 8'h00, 8'h43};
        v[3] = {4'd10, 8'h00, 8'h00, 8'h02, 8'hFF, 8'h80};
        v[4] = {4'd13, 8'h55, 8'h00, 8'h80, 8'h00, 8'h02};
        v[5] = {4'd14, 8'h90, 8'h11, 8'h00, 8'h90, 8'h80};
        v[6] = {4'd15, 8'h33, 8'h44, 8'hA5, 8'h33, 8'hA5};
        run_table("misc", v, 7);
    endtask

    task automatic test_back_to_back();
        logic [43:0] v [];
        v = new[5];
        v[0] = {4'd0,  8'h01, 8'h01, 8'h00, 8'h02, 8'h00};
        v[1] = {4'd4,  8'h0F, 8'h0F, 8'h00, 8'h00, 8'h02};
        v[2] = {4'd10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02};
        v[3] = {4'd11, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h01};
        v[4] = {4'd9,  8'h00, 8'h7F, 8'h00, 8'h80, 8'h80};
        run_table("b2b", v, 5);
    endtask

    task automatic test_reset_midstream();
        rst = 1'b0;
        step(4'd3, 8'hFF, 8'hFF, 8'hFF);
        n_cmp++;
        if (result !== 8'h00 || status_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got %h/%h expected 00/00", result, status_out);
        end
        rst = 1'b1;
        step(4'd3, 8'h12, 8'h40, 8'h00);
        n_cmp++;
        if (result !== 8'h52 || status_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_release: got %h/%h expected 52/00", result, status_out);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b0;
        op          = 4'd0;
        accumulator = 8'h00;
        operand_2   = 8'h00;
        status      = 8'h00;
        @(negedge clk);
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_misc();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
